memory_access_stage: RTL

- Pipeline stage directly downstream of the execution stage.
- Consumes the ALU result (as data address), the store value (valRm) and the memory read/write enables.
- Performs the data-memory transaction over a req/ack handshake to an external data memory. Stalls the pipeline with `freeze` until the access completes.
- Provides the loaded word to write-back; non-memory instructions pass with zero stall.

---
 rtl/memory_access_stage_pkg.sv | 13 +
 rtl/memory_access_stage_if.sv | 23 ++
 rtl/memory_access_stage_mem_addr_mapper.sv | 26 ++
 rtl/memory_access_stage.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access pipeline stage.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memStage_e;

  // Byte address that maps onto data-memory word 0.
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

endpackage : memory_access_stage_pkg

// File: rtl/memory_access_stage_if.sv
// Request/acknowledge bus between the memory access stage and the data memory.
interface memory_access_stage_if #(
  parameter int ADDR_W = 6
);

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              memAck;
  logic [31:0]       memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );

endinterface : memory_access_stage_if

// File: rtl/memory_access_stage_mem_addr_mapper.sv
// Translates an ALU byte address into a data-memory word index and flags
// addresses that fall outside the mapped window.
module mem_addr_mapper
  import memory_access_stage_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int          ADDR_W    = 6
) (
  input  logic [31:0]       aluResult,
  output logic [ADDR_W-1:0] wordIndex,
  output logic              outOfRange
);

  logic [31:0] offset;
  logic [31:0] wordOffset;

  // Byte offset into the window, then drop the byte-lane bits; anything left
  // above the index width means the address lies past the last word.
  always_comb begin
    offset     = aluResult - ADDR_BASE;
    wordOffset = offset >> 2;
    wordIndex  = wordOffset[ADDR_W-1:0];
    outOfRange = (aluResult < ADDR_BASE) || ((wordOffset >> ADDR_W) != 32'd0);
  end

endmodule : mem_addr_mapper

// File: rtl/memory_access_stage.sv
// Memory access stage: issues one data-memory transaction per load/store,
// stalls upstream while it is outstanding and returns loaded data to write-back.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a load/store; non-memory instructions pass unstalled
// REQ   | request outstanding on the memory bus; upstream frozen
// DONE  | access finished; one cycle where enables are ignored so the
//       | completed instruction leaves the stage and is not re-issued
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = ADDR_BASE_DEFAULT,
  parameter int          ADDR_W         = 6,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memoryReadEnabled,
  input  logic                  memoryWriteEnabled,
  input  logic [31:0]           aluResult,
  input  logic [31:0]           valRm,
  output logic                  freeze,
  output logic [31:0]           readData,
  output logic                  readDataValid,
  output logic                  busError,
  memory_access_stage_if.master memBus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timer counts down from TIMEOUT_CYCLES-1; terminal count in the last
  // permitted REQ cycle.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  memStage_e         state;
  memStage_e         stateNext;
  logic              start;
  logic              isWrite;
  logic              outOfRange;
  logic              timeoutHit;
  logic [ADDR_W-1:0] wordIndex;
  logic [TW-1:0]     timeoutCount;

  mem_addr_mapper #(
    .ADDR_BASE (ADDR_BASE),
    .ADDR_W    (ADDR_W)
  ) u_mapper (
    .aluResult  (aluResult),
    .wordIndex  (wordIndex),
    .outOfRange (outOfRange)
  );

  assign start      = memoryReadEnabled | memoryWriteEnabled;
  assign isWrite    = memoryWriteEnabled;
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (timeoutCount == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and the combinational stall request.
  always_comb begin
    stateNext = state;
    freeze    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          freeze    = 1'b1;
          stateNext = outOfRange ? DONE : REQ;
        end
      end
      REQ: begin
        freeze = 1'b1;
        if (memBus.memAck || timeoutHit) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bus outputs, timeout timer, load data and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      memBus.memReq   <= 1'b0;
      memBus.memWe    <= 1'b0;
      memBus.memAddr  <= '0;
      memBus.memWdata <= '0;
      readData        <= '0;
      readDataValid   <= 1'b0;
      busError        <= 1'b0;
      timeoutCount    <= '0;
    end else begin
      readDataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!outOfRange) begin
              memBus.memReq   <= 1'b1;
              memBus.memWe    <= isWrite;
              memBus.memAddr  <= wordIndex;
              memBus.memWdata <= valRm;
              timeoutCount    <= TIMEOUT_LOAD;
            end else begin
              busError <= 1'b1;
              if (!isWrite) begin
                readData      <= '0;
                readDataValid <= 1'b1;
              end
            end
          end
        end
        REQ: begin
          if (memBus.memAck) begin
            memBus.memReq <= 1'b0;
            timeoutCount  <= '0;
            if (!memBus.memWe) begin
              readData      <= memBus.memRdata;
              readDataValid <= 1'b1;
            end
          end else if (timeoutHit) begin
            memBus.memReq <= 1'b0;
            busError      <= 1'b1;
            if (!memBus.memWe) begin
              readData      <= '0;
              readDataValid <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            timeoutCount <= timeoutCount - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : memory_access_stage
